// File: rtl/line_serializer.sv
// line_serializer: double-buffered line-to-pixel serializer.
// A complete line is captured into a shadow register through a valid/ready
// handshake. On START it is moved into a working shift register and shifted
// out one pixel per PIX_EN strobe. Bit 0 of every line is the leftmost pixel.
module line_serializer #(
    parameter int LINE_W = 640,
    parameter int COL_W  = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [0:LINE_W-1] i_line_in,
    input  logic              i_line_valid,
    output logic              o_line_ready,
    input  logic              i_start,
    input  logic              i_pix_en,
    output logic              o_pixel_out,
    output logic              o_pixel_active,
    output logic [COL_W-1:0]  o_col,
    output logic              o_line_done,
    output logic              o_underrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [COL_W-1:0]  r_col;
    logic [COL_W-1:0]  w_col_nxt;
    logic [0:LINE_W-1] r_work;
    logic [0:LINE_W-1] w_work_nxt;
    logic [0:LINE_W-1] r_shadow;
    logic              r_sfull;
    logic              r_line_done;
    logic              w_line_done_nxt;
    logic              r_underrun;
    logic              w_underrun_nxt;
    logic              w_load;
    logic              w_capture;

    // Shadow accepts a line only when empty and not held in reset.
    assign o_line_ready = !r_sfull && !i_reset;
    assign w_capture    = i_line_valid && o_line_ready;

    assign o_pixel_active = (r_state == SHIFT);
    assign o_pixel_out    = o_pixel_active & r_work[0];
    assign o_col          = r_col;
    assign o_line_done    = r_line_done;
    assign o_underrun     = r_underrun;

    // Next-state logic: start of line (load or blank underrun) and pixel shifting.
    always_comb begin
        w_state_nxt     = r_state;
        w_col_nxt       = r_col;
        w_work_nxt      = r_work;
        w_line_done_nxt = 1'b0;
        w_underrun_nxt  = 1'b0;
        w_load          = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = SHIFT;
                    w_col_nxt   = {COL_W{1'b0}};
                    if (r_sfull) begin
                        w_work_nxt = r_shadow;
                        w_load     = 1'b1;
                    end else begin
                        // No line buffered: emit a blank line and flag it.
                        w_work_nxt     = {LINE_W{1'b0}};
                        w_underrun_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                // START is deliberately ignored while a line is in flight.
                if (i_pix_en) begin
                    if (r_col == LAST_COL) begin
                        w_state_nxt     = IDLE;
                        w_col_nxt       = {COL_W{1'b0}};
                        w_work_nxt      = {LINE_W{1'b0}};
                        w_line_done_nxt = 1'b1;
                    end else begin
                        w_work_nxt = {r_work[1:LINE_W-1], 1'b0};
                        w_col_nxt  = r_col + COL_W'(1);
                    end
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_col_nxt   = {COL_W{1'b0}};
                w_work_nxt  = {LINE_W{1'b0}};
            end
        endcase
    end

    // State, column, working line and one-cycle status pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_col       <= {COL_W{1'b0}};
            r_work      <= {LINE_W{1'b0}};
            r_line_done <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_work      <= w_work_nxt;
            r_line_done <= w_line_done_nxt;
            r_underrun  <= w_underrun_nxt;
        end
    end

    // Shadow buffer: captures independently of the shift state machine.
    // A transfer needs SFULL=1 and a capture needs SFULL=0, so they never collide.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shadow <= {LINE_W{1'b0}};
            r_sfull  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_shadow <= i_line_in;
            end
            if (w_load) begin
                r_sfull <= 1'b0;
            end else if (w_capture) begin
                r_sfull <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_line_serializer.sv
// Testbench for line_serializer: vector table, directed multi-cycle
// sequences and random traffic, all checked against a line/pixel-index model.
module tb_line_serializer;

    localparam int LINE_W = 640;
    localparam int COL_W  = 10;

    logic              clk = 1'b0;
    logic              i_reset = 1'b1;
    logic [0:LINE_W-1] i_line_in = '0;
    logic              i_line_valid = 1'b0;
    logic              i_start = 1'b0;
    logic              i_pix_en = 1'b0;
    logic              o_line_ready;
    logic              o_pixel_out;
    logic              o_pixel_active;
    logic [COL_W-1:0]  o_col;
    logic              o_line_done;
    logic              o_underrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    line_serializer #(.LINE_W(LINE_W), .COL_W(COL_W)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_line_in      (i_line_in),
        .i_line_valid   (i_line_valid),
        .o_line_ready   (o_line_ready),
        .i_start        (i_start),
        .i_pix_en       (i_pix_en),
        .o_pixel_out    (o_pixel_out),
        .o_pixel_active (o_pixel_active),
        .o_col          (o_col),
        .o_line_done    (o_line_done),
        .o_underrun     (o_underrun)
    );

    always #5 clk = ~clk;

    // Reference model: a buffered line plus the line being played out,
    // addressed by pixel index.
    bit                m_active = 1'b0;
    int                m_pos    = 0;
    logic [0:LINE_W-1] m_line   = '0;
    logic [0:LINE_W-1] m_shadow = '0;
    bit                m_sfull  = 1'b0;
    bit                m_done   = 1'b0;
    bit                m_under  = 1'b0;

    logic [0:LINE_W-1] zero_line;
    logic [0:LINE_W-1] pat1;
    logic [0:LINE_W-1] pat2;

    task automatic model_step(input bit rst, input bit valid, input bit start,
                              input bit pix, input logic [0:LINE_W-1] line);
        bit cap;
        cap = valid && !m_sfull;
        if (rst) begin
            m_active = 1'b0; m_pos = 0; m_line = '0; m_shadow = '0;
            m_sfull = 1'b0; m_done = 1'b0; m_under = 1'b0;
        end else begin
            m_done  = 1'b0;
            m_under = 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                    if (m_sfull) begin
                        m_line  = m_shadow;
                        m_sfull = 1'b0;
                    end else begin
                        m_line  = '0;
                        m_under = 1'b1;
                    end
                end
            end else if (pix) begin
                if (m_pos == LINE_W - 1) begin
                    m_active = 1'b0;
                    m_pos    = 0;
                    m_done   = 1'b1;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
            if (cap) begin
                m_shadow = line;
                m_sfull  = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        logic [14:0] got;
        logic [14:0] exp;
        bit          e_pix;
        e_pix = m_active ? m_line[m_pos] : 1'b0;
        got = {o_line_ready, o_pixel_active, o_col, o_pixel_out, o_line_done, o_underrun};
        exp = {(!m_sfull && !i_reset), m_active, 10'(m_pos), e_pix, m_done, m_under};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL model cyc=%0d got=%h want=%h (rdy,act,col,pix,done,und)", cyc, got, exp);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, exp);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare after it.
    task automatic cycle(input bit rst, input bit valid, input bit start,
                         input bit pix, input logic [0:LINE_W-1] line);
        i_reset = rst; i_line_valid = valid; i_start = start;
        i_pix_en = pix; i_line_in = line;
        @(posedge clk);
        model_step(rst, valid, start, pix, line);
        cyc++;
        #1;
        check_model();
    endtask

    function automatic logic [0:LINE_W-1] rand_line();
        logic [0:LINE_W-1] l;
        for (int i = 0; i < LINE_W; i++) l[i] = $urandom_range(0, 1) == 1;
        return l;
    endfunction

    typedef struct {
        bit rst; bit valid; bit start; bit pix; int pat;
        bit e_ready; bit e_active; int e_col; bit e_pix; bit e_done; bit e_under;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int ones, colsum, early, mism, holdbad, sawdone;
        logic [0:LINE_W-1] sel;

        zero_line = '0;
        pat1 = '0; pat1[0] = 1'b1; pat1[LINE_W-1] = 1'b1;
        for (int i = 0; i < LINE_W; i++) pat2[i] = (i % 2) == 0;

        //          rst v s p pat  rdy act col pix done und
        tbl[0]  = '{1, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 2,  0, 1, 0, 0, 0, 1};
        tbl[4]  = '{0, 0, 0, 1, 0,  0, 1, 1, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 1, 1,  0, 1, 2, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 1};
        tbl[9]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 0, 0, 2,  0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 0, 0,  1, 1, 0, 1, 0, 0};
        tbl[12] = '{0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 1, 0,  1, 1, 2, 1, 0, 0};
        tbl[14] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};

        for (int r = 0; r < 15; r++) begin
            sel = (tbl[r].pat == 1) ? pat1 : ((tbl[r].pat == 2) ? pat2 : zero_line);
            cycle(tbl[r].rst, tbl[r].valid, tbl[r].start, tbl[r].pix, sel);
            chk($sformatf("vec%0d_ready", r), o_line_ready, tbl[r].e_ready);
            chk($sformatf("vec%0d_active", r), o_pixel_active, tbl[r].e_active);
            chk($sformatf("vec%0d_col", r), o_col, tbl[r].e_col);
            chk($sformatf("vec%0d_pix", r), o_pixel_out, tbl[r].e_pix);
            chk($sformatf("vec%0d_done", r), o_line_done, tbl[r].e_done);
            chk($sformatf("vec%0d_under", r), o_underrun, tbl[r].e_under);
        end

        // Normal line: pixels only at the two edge columns.
        cycle(1, 0, 0, 0, zero_line);
        cycle(0, 1, 0, 0, pat1);
        chk("n_ready_after_cap", o_line_ready, 0);
        cycle(0, 0, 1, 0, zero_line);
        chk("n_active_after_start", o_pixel_active, 1);
        ones = 0; colsum = 0; early = 0;
        for (int k = 0; k < LINE_W; k++) begin
            if (o_pixel_out) begin ones++; colsum += int'(o_col); end
            cycle(0, 0, 0, 1, zero_line);
            if (k < LINE_W - 1 && o_line_done) early++;
        end
        chk("n_done", o_line_done, 1);
        chk("n_idle_after", o_pixel_active, 0);
        chk("n_ones", ones, 2);
        chk("n_colsum", colsum, LINE_W - 1);
        chk("n_early_done", early, 0);
        cycle(0, 0, 0, 0, zero_line);
        chk("n_done_pulse", o_line_done, 0);

        // Underrun: blank line, one-cycle flag, LINE_DONE still pulses.
        cycle(0, 0, 1, 0, zero_line);
        chk("u_under", o_underrun, 1);
        ones = 0; early = 0;
        for (int k = 0; k < LINE_W; k++) begin
            if (o_pixel_out) ones++;
            cycle(0, 0, 0, 1, zero_line);
            if (k == 0) chk("u_under_pulse", o_underrun, 0);
            if (k < LINE_W - 1 && o_line_done) early++;
        end
        chk("u_done", o_line_done, 1);
        chk("u_ones", ones, 0);
        chk("u_early_done", early, 0);

        // Back-pressure: B waits until A moves out of the shadow.
        cycle(0, 1, 0, 0, pat1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0, 0, pat2);
            chk("b_ready_held", o_line_ready, 0);
        end
        cycle(0, 1, 1, 0, pat2);
        chk("b_ready_after_xfer", o_line_ready, 1);
        cycle(0, 1, 0, 1, pat2);
        chk("b_ready_after_capB", o_line_ready, 0);
        sawdone = 0;
        for (int k = 0; k < 700 && sawdone == 0; k++) begin
            cycle(0, 0, 0, 1, zero_line);
            if (o_line_done) sawdone = 1;
        end
        chk("b_lineA_done", sawdone, 1);
        cycle(0, 0, 1, 0, zero_line);
        mism = 0;
        for (int k = 0; k < LINE_W; k++) begin
            if (o_pixel_out !== pat2[k]) mism++;
            cycle(0, 0, 0, 1, zero_line);
        end
        chk("b_lineB_mism", mism, 0);
        chk("b_lineB_done", o_line_done, 1);

        // Sparse strobe: output holds between strobes.
        cycle(0, 1, 0, 0, pat2);
        cycle(0, 0, 1, 0, zero_line);
        holdbad = 0; early = 0;
        for (int k = 0; k < LINE_W; k++) begin
            for (int j = 0; j < 3; j++) begin
                cycle(0, 0, 0, 0, zero_line);
                if (int'(o_col) != k || o_pixel_out !== pat2[k]) holdbad++;
                if (o_line_done) early++;
            end
            cycle(0, 0, 0, 1, zero_line);
            if (k < LINE_W - 1 && o_line_done) early++;
        end
        chk("s_hold", holdbad, 0);
        chk("s_early_done", early, 0);
        chk("s_done", o_line_done, 1);

        // Spurious START at column 100, then reset at column 300.
        cycle(0, 1, 0, 0, pat1);
        cycle(0, 0, 1, 0, zero_line);
        cycle(0, 1, 0, 1, pat2);
        for (int k = 0; k < 99; k++) cycle(0, 0, 0, 1, zero_line);
        chk("p_col100", o_col, 100);
        cycle(0, 0, 1, 0, zero_line);
        chk("p_col_hold", o_col, 100);
        chk("p_no_under", o_underrun, 0);
        chk("p_sfull_kept", o_line_ready, 0);
        cycle(0, 0, 0, 1, zero_line);
        chk("p_col101", o_col, 101);
        for (int k = 0; k < 199; k++) cycle(0, 0, 0, 1, zero_line);
        chk("r_col300", o_col, 300);
        cycle(1, 0, 0, 1, zero_line);
        sawdone = o_line_done;
        cycle(0, 0, 0, 0, zero_line);
        if (o_line_done) sawdone = 1;
        chk("r_active", o_pixel_active, 0);
        chk("r_col", o_col, 0);
        chk("r_ready", o_line_ready, 1);
        chk("r_no_done", sawdone, 0);
        cycle(0, 0, 1, 0, zero_line);
        chk("r_under_after_reset", o_underrun, 1);
        cycle(1, 0, 0, 0, zero_line);

        // Random traffic against the model.
        for (int n = 0; n < 6000; n++) begin
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rand_line());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
